sf_stream_mavg: RTL and testbench
=================================

// Module: sf_stream_mavg
// PURPOSE
//  Streaming multi-channel moving-average (smoothing) filter; next generation of the SF block.
//  - Samples arrive one per handshake, tagged with a channel; per-channel running sum over a power-of-two window.
//  - One averaged sample is emitted per accepted input once that channel's window is full.
//  - Sits between the sample source and downstream consumers. Valid/ready on both sides, no whole-frame output array.
// PARAMETERS
//  DATA_WIDTH  8  unsigned sample width (bits)
//  WIN_LOG2    2  log2 of window length; WIN = 2**WIN_LOG2 (0..6)
//  CHANNELS    2  number of independent channels (>=1)
// PORTS
//  clk       in   1                     clock, all logic on rising edge
//  rst       in   1                     synchronous, active-high reset
//  clear     in   1                     synchronous clear of all channel state (one-cycle pulse)
//  s_valid   in   1                     input sample valid
//  s_ready   out  1                     block can accept a sample
//  s_chan    in   max(1,$clog2(CHANNELS))  channel tag of input sample
//  s_data    in   DATA_WIDTH            input sample
//  m_valid   out  1                     averaged output valid
//  m_ready   in   1                     downstream accepts output
//  m_chan    out  max(1,$clog2(CHANNELS))  channel tag of output
//  m_data    out  DATA_WIDTH            averaged sample
//  err_chan  out  1                     sticky: an input arrived with s_chan >= CHANNELS
// BEHAVIOUR
//  - Reset: m_valid=0, m_chan=0, m_data=0, err_chan=0; every channel fill=0, wptr=0, sum=0. Buffer RAM is not reset.
//  - Accept: s_valid && s_ready. s_ready = !clear && (!m_valid || m_ready), so there is one output register and full throughput.
//  - Per channel state: buf[WIN] of samples, wptr (WIN_LOG2 bits, wraps WIN-1 -> 0).
//    Also fill (WIN_LOG2+1 bits, saturates at WIN) and sum (DATA_WIDTH+WIN_LOG2 bits; cannot overflow).
//  - On accept for channel c:
//    - old = (fill==WIN) ? buf[wptr] : 0
//    - sum_n = sum - old + s_data
//    - buf[wptr] <= s_data; wptr++; fill saturating++; sum <= sum_n.
//  - Output: when fill_next==WIN (i.e. on the WIN-th sample and every later one), the output register loads next cycle.
//    It gets m_valid=1, m_chan=c, m_data=sum_n>>WIN_LOG2. Latency: 1 cycle from accept to m_valid.
//  - Warm-up samples (fill_next<WIN) are accepted and produce no output.
//    If the output register is held, m_valid stays 1. Otherwise it clears when m_ready is high.
//  - m_valid && !m_ready: m_data/m_chan held stable, s_ready=0 (no sample lost or overwritten).
//  - WIN_LOG2=0: output equals input, one cycle later.
//  - Bad channel: if s_chan>=CHANNELS, the sample is accepted and dropped, with no state change. err_chan<=1 (sticky until rst/clear).
//  - clear: sets all fill/wptr/sum to 0 and err_chan to 0. A pending output still completes its handshake. s_ready=0 in the clear cycle.
//  - Simultaneous events: rst overrides everything. clear and s_valid in the same cycle means the input is not accepted. Output accept and input accept in the same cycle are both performed.
//  - rst mid-stream: outputs and pending output are dropped. Warm-up restarts for all channels.
// CONFIGURATION
//  SF_STREAM_ROUND_EN defined:
//    m_data = (sum_n + (WIN>>1)) >> WIN_LOG2, i.e. round half up. This cannot exceed 2**DATA_WIDTH-1. For WIN_LOG2=0 it is identical to truncation.
//  SF_STREAM_ROUND_EN undefined: m_data = sum_n >> WIN_LOG2 (truncate). This is the default.
// TESTING  (DATA_WIDTH=8, WIN_LOG2=2, CHANNELS=2, m_ready=1 unless stated)
//  1. Warm-up and steady state.
//     Stimulus: ch0 inputs 4,8,12,16,20 back-to-back.
//     Response: no output for the first 3 inputs, then m_data=10 and then 14, each 1 cycle after its accept, m_chan=0.
//  2. Channel independence.
//     Stimulus: interleave ch0: 0,0,0,100 with ch1: 40,40,40,40.
//     Response: outputs in input order, ch0 -> 25 and ch1 -> 40. Channel states do not mix.
//  3. Backpressure.
//     Stimulus: after output 10 of test 1, hold m_ready=0 for 5 cycles with s_valid=1.
//     Response: s_ready=0, m_data=10 stable, and the next output is 14 with no sample skipped.
//  4. Rounding.
//     Stimulus: ch0 inputs 1,1,2,2.
//     Response: m_data=1 without SF_STREAM_ROUND_EN; m_data=2 with it defined.
//  5. Full scale and wrap.
//     Stimulus: ch1 inputs 255 eight times, then 0.
//     Response: five outputs of 255 (no overflow), then 191, across the wptr wrap.
//  6. clear/rst mid-stream and bad channel.
//     - Send 2 samples on ch0, then pulse clear, then 4,4,4,4: only one output, value 4.
//     - An input on s_chan=3 sets err_chan=1. rst returns it and every output to its reset value.

Source files
------------

// File: rtl/sf_stream_mavg.sv
// sf_stream_mavg: streaming multi-channel moving-average filter.
// Each channel keeps a circular buffer of its last WIN = 2**WIN_LOG2 samples
// and a running sum. Once a channel's window is full, every accepted sample
// produces one averaged output through a single output register.
// Optional build macro: SF_STREAM_ROUND_EN selects round-half-up averaging;
// without it the average is truncated.
module sf_stream_mavg #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_LOG2   = 2,
  parameter int CHANNELS   = 2,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [CW-1:0]         s_chan,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CW-1:0]         m_chan,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  err_chan
);

  localparam int WIN = 1 << WIN_LOG2;
  localparam int PW  = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
  localparam int FW  = WIN_LOG2 + 1;
  localparam int SW  = DATA_WIDTH + WIN_LOG2;

  localparam logic [PW-1:0] PTR_LAST  = PW'(WIN - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(WIN);
  localparam logic [SW-1:0] HALF      = SW'(WIN >> 1);

  // Per-channel state; the sample RAM is never reset, fill gates its use.
  logic [DATA_WIDTH-1:0] mem      [CHANNELS][WIN];
  logic [PW-1:0]         wptr     [CHANNELS];
  logic [FW-1:0]         fill     [CHANNELS];
  logic [SW-1:0]         chan_sum [CHANNELS];

  // Stage p0: combinational accept and running-sum update.
  logic                  chan_ok_p0;
  logic                  acc_p0;
  logic                  load_p0;
  logic [CW-1:0]         ch_p0;
  logic [PW-1:0]         ptr_p0;
  logic [PW-1:0]         ptr_nx_p0;
  logic [FW-1:0]         fill_p0;
  logic [FW-1:0]         fill_nx_p0;
  logic [SW-1:0]         old_p0;
  logic [SW-1:0]         sum_nx_p0;

  // Stage p1: output register.
  logic                  vld_p1;
  logic [CW-1:0]         chan_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  err_p1;

  // Averaging: optional round-half-up, then divide by the window length.
  // sum + WIN/2 stays below 2**SW, so no extra headroom bit is needed.
  function automatic logic [DATA_WIDTH-1:0] avg_fn(input logic [SW-1:0] s);
    logic [SW-1:0] t;
`ifdef SF_STREAM_ROUND_EN
    t = s + HALF;
`else
    t = s;
`endif
    avg_fn = DATA_WIDTH'(t >> WIN_LOG2);
  endfunction

  // A power-of-two channel count cannot encode an out-of-range tag.
  if (CHANNELS == (1 << CW)) begin : g_chan_pow2
    assign chan_ok_p0 = 1'b1;
  end else begin : g_chan_npow2
    assign chan_ok_p0 = (s_chan < CW'(CHANNELS));
  end

  assign s_ready  = !clear && (!vld_p1 || m_ready);
  assign acc_p0   = s_valid && s_ready;
  assign m_valid  = vld_p1;
  assign m_chan   = chan_p1;
  assign m_data   = data_p1;
  assign err_chan = err_p1;

  // Look up the addressed channel and form its next sum, fill and pointer.
  always_comb begin
    ch_p0      = chan_ok_p0 ? s_chan : '0;
    ptr_p0     = wptr[ch_p0];
    fill_p0    = fill[ch_p0];
    old_p0     = (fill_p0 == FILL_FULL) ? SW'(mem[ch_p0][ptr_p0]) : '0;
    sum_nx_p0  = chan_sum[ch_p0] - old_p0 + SW'(s_data);
    fill_nx_p0 = (fill_p0 == FILL_FULL) ? fill_p0 : fill_p0 + 1'b1;
    ptr_nx_p0  = (ptr_p0 == PTR_LAST) ? '0 : ptr_p0 + 1'b1;
    load_p0    = acc_p0 && chan_ok_p0 && (fill_nx_p0 == FILL_FULL);
  end

  // Channel bookkeeping: restart warm-up on rst/clear, advance on accept.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wptr[i]     <= '0;
        fill[i]     <= '0;
        chan_sum[i] <= '0;
      end
    end else if (acc_p0 && chan_ok_p0) begin
      wptr[ch_p0]     <= ptr_nx_p0;
      fill[ch_p0]     <= fill_nx_p0;
      chan_sum[ch_p0] <= sum_nx_p0;
    end
  end

  // Sample RAM write: the new sample replaces the oldest slot.
  always_ff @(posedge clk) begin
    if (acc_p0 && chan_ok_p0) begin
      mem[ch_p0][ptr_p0] <= s_data;
    end
  end

  // Output register: load on a full-window accept, else drain on m_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      chan_p1 <= '0;
      data_p1 <= '0;
    end else if (load_p0) begin
      vld_p1  <= 1'b1;
      chan_p1 <= ch_p0;
      data_p1 <= avg_fn(sum_nx_p0);
    end else if (m_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  // Sticky flag for samples tagged with a nonexistent channel.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_p1 <= 1'b0;
    end else if (acc_p0 && !chan_ok_p0) begin
      err_p1 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sf_stream_mavg.sv
// Bench for sf_stream_mavg (DATA_WIDTH=8, WIN_LOG2=2). A second instance with
// three channels exercises the out-of-range channel tag.
module tb_sf_stream_mavg;
  localparam int WIN = 4;

  logic       clk = 1'b0;
  logic       rst, clear, m_ready;
  logic       s_valid, s_ready, m_valid, err_chan;
  logic [0:0] s_chan, m_chan;
  logic [7:0] s_data, m_data;

  logic       s_valid2, s_ready2, m_valid2, err2;
  logic [1:0] s_chan2, m_chan2;
  logic [7:0] s_data2, m_data2;

  int checks = 0;
  int passes = 0;

  int unsigned hist [2][$];
  int unsigned exp_d [$];
  int unsigned exp_c [$];
  bit          m_err;

  always #5 clk = ~clk;

  sf_stream_mavg #(.DATA_WIDTH(8), .WIN_LOG2(2), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan), .m_data(m_data),
    .err_chan(err_chan)
  );

  sf_stream_mavg #(.DATA_WIDTH(8), .WIN_LOG2(2), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .clear(clear),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_chan(s_chan2), .s_data(s_data2),
    .m_valid(m_valid2), .m_ready(m_ready), .m_chan(m_chan2), .m_data(m_data2),
    .err_chan(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: keep the last WIN samples per channel, average when full.
  function automatic void model_accept(input int ch, input int unsigned d);
    int unsigned s;
    if (ch >= 2) begin
      m_err = 1'b1;
      return;
    end
    hist[ch].push_back(d);
    if (hist[ch].size() > WIN) void'(hist[ch].pop_front());
    if (hist[ch].size() == WIN) begin
      s = 0;
      for (int k = 0; k < WIN; k++) s += hist[ch][k];
`ifdef SF_STREAM_ROUND_EN
      s += WIN / 2;
`endif
      exp_d.push_back(s / WIN);
      exp_c.push_back(ch);
    end
  endfunction

  // One clock: check outputs at the falling edge, update the model with the
  // handshakes that the coming rising edge performs.
  task automatic cycle(output bit acc);
    bit rdy;
    @(negedge clk);
    acc = 1'b0;
    if (rst) begin
      hist[0].delete();
      hist[1].delete();
      exp_d.delete();
      exp_c.delete();
      m_err = 1'b0;
    end else begin
      rdy = !clear && (exp_d.size() == 0 || m_ready);
      chk("s_ready", 32'(s_ready), 32'(rdy));
      chk("m_valid", 32'(m_valid), 32'(exp_d.size() != 0));
      if (exp_d.size() != 0) begin
        chk("m_data", 32'(m_data), exp_d[0]);
        chk("m_chan", 32'(m_chan), exp_c[0]);
        if (m_ready) begin
          void'(exp_d.pop_front());
          void'(exp_c.pop_front());
        end
      end
      chk("err_chan", 32'(err_chan), 32'(m_err));
      if (clear) begin
        hist[0].delete();
        hist[1].delete();
        m_err = 1'b0;
      end
      acc = s_valid && rdy;
      if (acc) model_accept(int'(s_chan), int'(s_data));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) cycle(a);
  endtask

  task automatic send(input int ch, input int d);
    bit a;
    int n;
    n = 0;
    s_valid = 1'b1;
    s_chan  = ch[0:0];
    s_data  = d[7:0];
    do begin
      cycle(a);
      n++;
    end while (!a && n < 50);
    checks++;
    assert (a) passes++;
    else $error("FAIL send_timeout observed=%0d cycles expected=accept", n);
    s_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    rst = 1'b1; clear = 1'b0; m_ready = 1'b1;
    s_valid = 1'b0; s_chan = '0; s_data = '0;
    s_valid2 = 1'b0; s_chan2 = '0; s_data2 = '0;
    idle(2);
    rst = 1'b0;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_chan", 32'(m_chan), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_err", 32'(err_chan), 0);
    chk("rst_err3", 32'(err2), 0);
    chk("rst_m_valid3", 32'(m_valid2), 0);

    // Warm-up, steady state, and backpressure
    send(0, 4);  chk("t1_warm1", 32'(m_valid), 0);
    send(0, 8);  chk("t1_warm2", 32'(m_valid), 0);
    send(0, 12); chk("t1_warm3", 32'(m_valid), 0);
    send(0, 16);
    chk("t1_valid", 32'(m_valid), 1);
    chk("t1_avg10", 32'(m_data), 10);
    chk("t1_chan", 32'(m_chan), 0);
    m_ready = 1'b0;
    s_valid = 1'b1; s_chan = 1'b0; s_data = 8'd20;
    repeat (5) begin
      cycle(a);
      chk("t3_hold", 32'(m_data), 10);
      chk("t3_sready", 32'(s_ready), 0);
    end
    m_ready = 1'b1;
    send(0, 20);
    chk("t3_avg14", 32'(m_data), 14);
    chk("t3_chan", 32'(m_chan), 0);

    // Channel independence
    pulse_clear();
    for (int i = 0; i < 4; i++) begin
      send(0, (i == 3) ? 100 : 0);
      if (i == 3) begin
        chk("t2_ch0", 32'(m_data), 25);
        chk("t2_ch0_tag", 32'(m_chan), 0);
      end
      send(1, 40);
      if (i == 3) begin
        chk("t2_ch1", 32'(m_data), 40);
        chk("t2_ch1_tag", 32'(m_chan), 1);
      end
    end

    // Rounding
    pulse_clear();
    send(0, 1); send(0, 1); send(0, 2); send(0, 2);
`ifdef SF_STREAM_ROUND_EN
    chk("t4_round", 32'(m_data), 2);
`else
    chk("t4_trunc", 32'(m_data), 1);
`endif

    // Full scale and pointer wrap
    pulse_clear();
    for (int i = 0; i < 8; i++) begin
      send(1, 255);
      if (i >= 3) chk("t5_full", 32'(m_data), 255);
    end
    send(1, 0);
    chk("t5_wrap", 32'(m_data), 191);
    chk("t5_chan", 32'(m_chan), 1);

    // clear mid warm-up
    pulse_clear();
    send(0, 9); send(0, 9);
    pulse_clear();
    for (int i = 0; i < 3; i++) begin
      send(0, 4);
      chk("t6_rewarm", 32'(m_valid), 0);
    end
    send(0, 4);
    chk("t6_valid", 32'(m_valid), 1);
    chk("t6_avg4", 32'(m_data), 4);
    idle(1);

    // Bad channel on the three-channel instance
    s_valid2 = 1'b1; s_chan2 = 2'd3; s_data2 = 8'd200;
    chk("bad_sready", 32'(s_ready2), 1);
    cycle(a);
    s_valid2 = 1'b0;
    chk("bad_err", 32'(err2), 1);
    chk("bad_nout", 32'(m_valid2), 0);
    for (int i = 0; i < 4; i++) begin
      s_valid2 = 1'b1; s_chan2 = 2'd0; s_data2 = 8'd8;
      cycle(a);
      s_valid2 = 1'b0;
      chk("bad_nostate", 32'(m_valid2), (i == 3) ? 1 : 0);
    end
    chk("bad_avg", 32'(m_data2), 8);
    chk("bad_sticky", 32'(err2), 1);
    pulse_clear();
    chk("bad_clear", 32'(err2), 0);

    // Randomized traffic with backpressure and occasional clear
    for (int i = 0; i < 600; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_chan  = 1'($urandom_range(0, 1));
      s_data  = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      m_ready = ($urandom_range(0, 3) != 0);
      clear   = ($urandom_range(0, 63) == 0);
      cycle(a);
    end
    s_valid = 1'b0; clear = 1'b0; m_ready = 1'b1;
    idle(2);

    // rst mid-stream with a held output
    for (int i = 0; i < 4; i++) send(1, 7);
    m_ready = 1'b0;
    s_valid2 = 1'b1; s_chan2 = 2'd3;
    idle(1);
    s_valid2 = 1'b0;
    idle(1);
    chk("rst_pend", 32'(m_valid), 1);
    chk("rst_pend_data", 32'(m_data), 7);
    chk("rst_pre_err3", 32'(err2), 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    m_ready = 1'b1;
    chk("rst2_m_valid", 32'(m_valid), 0);
    chk("rst2_m_data", 32'(m_data), 0);
    chk("rst2_m_chan", 32'(m_chan), 0);
    chk("rst2_err", 32'(err_chan), 0);
    chk("rst2_err3", 32'(err2), 0);
    for (int i = 0; i < 3; i++) begin
      send(1, 20);
      chk("rst2_warm", 32'(m_valid), 0);
    end
    send(1, 20);
    chk("rst2_valid", 32'(m_valid), 1);
    chk("rst2_avg", 32'(m_data), 20);
    chk("rst2_chan", 32'(m_chan), 1);
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
